// File: rtl/score_hand.sv
// Baccarat hand scorer: three card codes -> registered score mod 10; optional card_err via SCORE_HAND_CARD_ERR_EN.
// Latency 1 cycle, one result per cycle; no backpressure, inputs sampled every edge.
module score_hand (
  input  logic       clk,
  input  logic       resetb,
  input  logic [3:0] card1,
  input  logic [3:0] card2,
  input  logic [3:0] card3,
`ifdef SCORE_HAND_CARD_ERR_EN
  output logic       card_err,
`endif
  output logic [3:0] total
);

  // Aces and pips keep their face value; tens, faces and illegal codes score 0.
  function automatic logic [3:0] pip_val(input logic [3:0] c);
    return (c <= 4'd9) ? c : 4'd0;
  endfunction

  logic [4:0] sum;
  logic [3:0] total_nxt;

  always_comb begin
    sum = {1'b0, pip_val(card1)} + {1'b0, pip_val(card2)} + {1'b0, pip_val(card3)};
    total_nxt = sum[3:0];
    if (sum >= 5'd20)
      total_nxt = 4'(sum - 5'd20);
    else if (sum >= 5'd10)
      total_nxt = 4'(sum - 5'd10);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      total <= 4'd0;
    else
      total <= total_nxt;
  end

`ifdef SCORE_HAND_CARD_ERR_EN
  logic err_nxt;

  always_comb begin
    err_nxt = (card1 >= 4'd14) || (card2 >= 4'd14) || (card3 >= 4'd14);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      card_err <= 1'b0;
    else
      card_err <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_score_hand.sv
// Directed and exhaustive check of score_hand against a mod-10 reference model.
module tb_score_hand;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] card1 = 4'd0;
  logic [3:0] card2 = 4'd0;
  logic [3:0] card3 = 4'd0;
  logic [3:0] total;
`ifdef SCORE_HAND_CARD_ERR_EN
  logic       card_err;
`endif

  int total_n = 0;
  int bad_n = 0;

  score_hand dut (
    .clk(clk),
    .resetb(resetb),
    .card1(card1),
    .card2(card2),
    .card3(card3),
`ifdef SCORE_HAND_CARD_ERR_EN
    .card_err(card_err),
`endif
    .total(total)
  );

  always #5 clk = ~clk;

  function automatic int points(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int ref_score(input int a, input int b, input int c);
    return (points(a) + points(b) + points(c)) % 10;
  endfunction

  logic [3:0] exp_total = 4'd0;
  logic       exp_err = 1'b0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      exp_total <= 4'd0;
      exp_err   <= 1'b0;
    end else begin
      exp_total <= 4'(ref_score(card1, card2, card3));
      exp_err   <= (card1 > 13) || (card2 > 13) || (card3 > 13);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total_n++;
    if (act !== req) begin
      bad_n++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_total", {4'd0, total}, {4'd0, exp_total});
`ifdef SCORE_HAND_CARD_ERR_EN
    chk("model_err", {7'd0, card_err}, {7'd0, exp_err});
`endif
  end

  // Called just after a rising edge: drive cards, take the next edge, check literal.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] req, input string nm);
    card1 = a;
    card2 = b;
    card3 = c;
    @(posedge clk);
    #1;
    chk(nm, {4'd0, total}, {4'd0, req});
  endtask

  initial begin
    #12;
    chk("reset_total", {4'd0, total}, 8'd0);
`ifdef SCORE_HAND_CARD_ERR_EN
    chk("reset_err", {7'd0, card_err}, 8'd0);
`endif
    @(posedge clk);
    #1;
    resetb = 1'b1;
    @(posedge clk);
    #1;

    step(4'd1,  4'd7,  4'd1,  4'd9, "no_face");
    step(4'd1,  4'd7,  4'd13, 4'd8, "one_face");
    step(4'd1,  4'd13, 4'd13, 4'd1, "two_face");
    step(4'd13, 4'd13, 4'd13, 4'd0, "all_king");
    step(4'd10, 4'd11, 4'd12, 4'd0, "faces_a");
    step(4'd12, 4'd10, 4'd11, 4'd0, "faces_b");
    step(4'd11, 4'd12, 4'd10, 4'd0, "faces_c");
    step(4'd9,  4'd9,  4'd9,  4'd7, "wrap_27");
    step(4'd5,  4'd5,  4'd0,  4'd0, "wrap_10");
    step(4'd0,  4'd0,  4'd0,  4'd0, "empty");
    step(4'd7,  4'd1,  4'd1,  4'd9, "order_b");
    step(4'd1,  4'd2,  4'd3,  4'd6, "pre_lat");

    card1 = 4'd9;
    card2 = 4'd9;
    card3 = 4'd9;
    #1;
    chk("before_edge", {4'd0, total}, 8'd6);
    @(posedge clk);
    #1;
    chk("after_edge", {4'd0, total}, 8'd7);

    card1 = 4'd5;
    card2 = 4'd6;
    card3 = 4'd0;
    #2;
    resetb = 1'b0;
    #1;
    chk("async_reset", {4'd0, total}, 8'd0);
    #3;
    resetb = 1'b1;
    #1;
    chk("held_after_rel", {4'd0, total}, 8'd0);
    @(posedge clk);
    #1;
    chk("first_edge", {4'd0, total}, 8'd1);

`ifdef SCORE_HAND_CARD_ERR_EN
    step(4'd14, 4'd1, 4'd2, 4'd3, "err_total");
    chk("err_set", {7'd0, card_err}, 8'd1);
    step(4'd1, 4'd2, 4'd3, 4'd6, "ok_total");
    chk("err_clr", {7'd0, card_err}, 8'd0);
`else
    step(4'd14, 4'd1, 4'd2, 4'd3, "illegal_14");
    step(4'd1, 4'd15, 4'd15, 4'd1, "illegal_15");
`endif

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 16; c++) begin
          card1 = 4'(a);
          card2 = 4'(b);
          card3 = 4'(c);
          @(posedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
